// File: rtl/ssf_io_pkg.sv
// ============================================================================
// Module      : ssf_io_pkg
// Description : Shared port indices and status-word layout for the ssf
//               processor I/O responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssf_io_pkg;

  // Input-side port indices (bit positions within req_in)
  localparam int IN_SAMPLE  = 0;
  localparam int IN_STATUS  = 1;

  // Output-side port indices (bit positions within out_en)
  localparam int OUT_SAMPLE = 0;
  localparam int OUT_CTRL   = 1;

  // Status word layout: the two sticky flags live at the top of the word,
  // so their positions depend on the data width.
  localparam int ST_TXCNT_LSB = 8;
  localparam int ST_RXCNT_LSB = 0;
  localparam int ST_CNT_W     = 8;

  function automatic int st_ovf(input int nubits);
    return nubits - 1;
  endfunction

  function automatic int st_udf(input int nubits);
    return nubits - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssf_sync_fifo.sv
// ============================================================================
// Module      : ssf_sync_fifo
// Description : Single-clock FIFO with simultaneous push/pop, registered
//               occupancy count and a zero-when-empty head output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssf_sync_fifo #(
  parameter int NUBITS = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [NUBITS-1:0]        push_data,
  input  logic                     pop,
  output logic [NUBITS-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [NUBITS-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Empty FIFO presents zero so downstream muxes need no extra gating
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are discarded logically by the pointer reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssf_io_port.sv
// ============================================================================
// Module      : ssf_io_port
// Description : Two-port I/O responder for the ssf core. Input port 0 reads
//               an RX sample FIFO, input port 1 reads a status word; output
//               port 0 feeds a TX FIFO, output port 1 loads a control reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssf_io_port
  import ssf_io_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        req_in,
  output logic [NUBITS-1:0] io_in,
  input  logic [1:0]        out_en,
  input  logic [NUBITS-1:0] io_out,
  output logic [NUBITS-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [NUBITS-1:0] ctrl_reg,
  output logic              underflow,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [NUBITS-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [AW:0]       rx_count;
  logic              tx_full;
  logic              tx_empty;
  logic [AW:0]       tx_count;

  logic              rx_push;
  logic              rx_pop;
  logic              rd_status;
  logic              udf_set;
  logic              ovf_set;
  logic              tx_pop;
  logic [NUBITS-1:0] status;

  // Request decode: the illegal 2'b11 request behaves as a sample read
  assign rd_status = req_in[IN_STATUS] & ~req_in[IN_SAMPLE];
  assign rx_push   = s_valid & s_ready;
  assign rx_pop    = req_in[IN_SAMPLE] & ~rx_empty;
  assign udf_set   = req_in[IN_SAMPLE] & rx_empty;
  assign tx_pop    = m_valid & m_ready;
  assign ovf_set   = out_en[OUT_SAMPLE] & tx_full & ~tx_pop;

  assign s_ready   = ~rx_full;
  assign m_valid   = ~tx_empty;

  ssf_sync_fifo #(.NUBITS(NUBITS), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (s_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  ssf_sync_fifo #(.NUBITS(NUBITS), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_en[OUT_SAMPLE]),
    .push_data (io_out),
    .pop       (tx_pop),
    .head      (m_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // Status word assembly and same-cycle read-data mux
  always_comb begin
    status = '0;
    status[st_ovf(NUBITS)] = overflow;
    status[st_udf(NUBITS)] = underflow;
    status[ST_TXCNT_LSB +: ST_CNT_W] = ST_CNT_W'(tx_count);
    status[ST_RXCNT_LSB +: ST_CNT_W] = ST_CNT_W'(rx_count);
    io_in = rd_status ? status : rx_head;
  end

  // Sticky error flags: a status read clears them, a new event in the same cycle wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (udf_set)        underflow <= 1'b1;
      else if (rd_status) underflow <= 1'b0;
      if (ovf_set)        overflow  <= 1'b1;
      else if (rd_status) overflow  <= 1'b0;
    end
  end

  // Control register loaded by writes to output port 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_reg <= '0;
    end else if (out_en[OUT_CTRL]) begin
      ctrl_reg <= io_out;
    end
  end

endmodule

`default_nettype wire
